prbs15_checker: RTL

PRBS15_CHECKER -- requirements
Module: prbs15_checker

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs15_byte_pred.sv | 26 ++
 rtl/prbs15_checker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 pattern/sequence checker.
package prbs_pkg;

  typedef enum logic [1:0] {IDLE, PATTERN, SEED, CHECK} state_t;

  localparam int PRBS_LEN = 15;
  localparam int TAP_A    = 14;
  localparam int TAP_B    = 13;

  localparam int               ERR_W   = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

  // Clamp at ERR_MAX instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [ERR_W-1:0] inc);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return s[ERR_W] ? ERR_MAX : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/prbs15_byte_pred.sv
// Bitwise PRBS-15 prediction over one byte, MSB first. The register shifts in
// the received bit, so one corrupted bit resynchronises within 15 bits.
module prbs15_byte_pred
  import prbs_pkg::*;
#(
  parameter int PATT_WIDTH = 8
) (
  input  logic [PRBS_LEN-1:0]   state,
  input  logic [PATT_WIDTH-1:0] byte_in,
  output logic [PATT_WIDTH-1:0] mask,
  output logic [PRBS_LEN-1:0]   next_state
);

  logic [PRBS_LEN-1:0] s;

  always_comb begin
    s    = state;
    mask = '0;
    for (int i = PATT_WIDTH - 1; i >= 0; i--) begin
      mask[i] = s[TAP_A] ^ s[TAP_B] ^ byte_in[i];
      s       = {s[PRBS_LEN-2:0], byte_in[i]};
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs15_checker.sv
// Checks n repetitions of a fixed word pattern, then seeds and tracks a
// self-synchronising PRBS-15 stream, counting bit errors and reporting lock.
module prbs15_checker
  import prbs_pkg::*;
#(
  parameter int PATT_WIDTH = 8,
  parameter int PATT_NUM   = 4,
  parameter int REPEAT_W   = 5,
  parameter int LOCK_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           start,
  input  logic [REPEAT_W-1:0]            n,
  input  logic [PATT_WIDTH*PATT_NUM-1:0] pattern,
  input  logic [PATT_WIDTH-1:0]          byte_in,
  input  logic                           byte_valid,
  output logic                           busy,
  output logic                           pattern_done,
  output logic                           pattern_err,
  output logic                           prbs_lock,
  output logic [ERR_W-1:0]               err_count
);

  localparam int IDX_W      = (PATT_NUM > 1) ? $clog2(PATT_NUM) : 1;
  localparam int CLEAN_W    = $clog2(LOCK_BYTES + 1);
  localparam int SEED_BYTES = (PRBS_LEN + PATT_WIDTH - 1) / PATT_WIDTH;
  localparam int SEED_W     = (SEED_BYTES > 1) ? $clog2(SEED_BYTES) : 1;
  localparam int NERR_W     = $clog2(PATT_WIDTH + 1);

  state_t                          state, state_nxt;
  logic [PATT_WIDTH*PATT_NUM-1:0]  pat_q;
  logic [REPEAT_W-1:0]             rep;
  logic [IDX_W-1:0]                idx;
  logic [SEED_W-1:0]               seed_cnt;
  logic [PRBS_LEN-1:0]             lfsr, lfsr_nxt;
  logic [PATT_WIDTH-1:0]           mask;
  logic [CLEAN_W-1:0]              clean;
  logic [NERR_W-1:0]               nerr;
  logic [PATT_WIDTH-1:0]           word;
  logic                            last_word, last_rep;

  prbs15_byte_pred #(.PATT_WIDTH(PATT_WIDTH)) u_pred (
    .state      (lfsr),
    .byte_in    (byte_in),
    .mask       (mask),
    .next_state (lfsr_nxt)
  );

  assign word      = pat_q[idx*PATT_WIDTH +: PATT_WIDTH];
  assign last_word = (idx == IDX_W'(PATT_NUM - 1));
  assign last_rep  = (rep == REPEAT_W'(1));

  always_comb begin
    nerr = '0;
    for (int i = 0; i < PATT_WIDTH; i++) nerr = nerr + NERR_W'(mask[i]);
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (n != '0) ? PATTERN : SEED;
    end else if (byte_valid) begin
      case (state)
        PATTERN: if (last_word && last_rep) state_nxt = SEED;
        SEED:    if (seed_cnt == SEED_W'(SEED_BYTES - 1)) state_nxt = CHECK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      pattern_done <= 1'b0;
      pattern_err  <= 1'b0;
      prbs_lock    <= 1'b0;
      err_count    <= '0;
      pat_q        <= '0;
      rep          <= '0;
      idx          <= '0;
      seed_cnt     <= '0;
      lfsr         <= '0;
      clean        <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      pattern_done <= 1'b0;
      if (start) begin
        pat_q       <= pattern;
        rep         <= n;
        idx         <= '0;
        seed_cnt    <= '0;
        lfsr        <= '0;
        clean       <= '0;
        pattern_err <= 1'b0;
        prbs_lock   <= 1'b0;
        err_count   <= '0;
      end else if (byte_valid) begin
        case (state)
          PATTERN: begin
            if (byte_in != word) begin
              pattern_err <= 1'b1;
              err_count   <= sat_add(err_count, ERR_W'(1));
            end
            if (last_word) begin
              idx <= '0;
              rep <= rep - REPEAT_W'(1);
              if (last_rep) pattern_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          SEED: begin
            lfsr     <= lfsr_nxt;
            seed_cnt <= seed_cnt + SEED_W'(1);
          end
          CHECK: begin
            lfsr      <= lfsr_nxt;
            err_count <= sat_add(err_count, ERR_W'(nerr));
            // Any errored byte drops lock and restarts the clean-byte run.
            if (mask != '0) begin
              prbs_lock <= 1'b0;
              clean     <= '0;
            end else begin
              if (clean != CLEAN_W'(LOCK_BYTES)) clean <= clean + CLEAN_W'(1);
              if (clean >= CLEAN_W'(LOCK_BYTES - 1)) prbs_lock <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
